mem_access_stage: RTL

//  MEM stage of the pipelined RV32I core, directly upstream of the load-data/writeback formatter.
//  - Takes the EX/MEM instruction and issues loads/stores to data memory over a valid/ready + response handshake.
//  - Aligns store data and generates byte enables; stalls the pipeline while memory is busy.
//  - Registers the MEM/WB outputs: raw read word, byte address, opcode, funct3, ALU result, rd.

---
 rtl/mem_pkg.sv | 39 +++
 rtl/store_align.sv | 28 ++
 rtl/mem_access_stage.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants, state encoding, request payload and access-legality helpers
// for the MEM stage.
package mem_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] rs2;
  } mem_op_t;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_H, F3_HU: return offset[0];
      F3_W:        return offset != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic is_legal_f3(input logic is_store, input logic [2:0] funct3);
    if (is_store) return funct3 inside {F3_B, F3_H, F3_W};
    return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/store_align.sv
// Replicates store data across byte lanes and builds the byte-enable mask.
module store_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_rs2,
  output logic [31:0] o_wdata_c,
  output logic [3:0]  o_be_c
);

  always_comb begin
    o_wdata_c = i_rs2;
    o_be_c    = 4'b1111;
    case (i_funct3)
      F3_B: begin
        o_wdata_c = {4{i_rs2[7:0]}};
        o_be_c    = 4'(4'b0001 << i_offset);
      end
      F3_H: begin
        o_wdata_c = {2{i_rs2[15:0]}};
        o_be_c    = 4'(4'b0011 << i_offset);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: issues loads/stores over a valid/ready + response handshake,
// stalls the pipeline while memory is busy and registers the MEM/WB payload.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EXMEM_valid,
  input  logic [6:0]  EXMEM_opcode,
  input  logic [2:0]  EXMEM_funct3,
  input  logic [4:0]  EXMEM_rd,
  input  logic [31:0] EXMEM_alu_out,
  input  logic [31:0] EXMEM_rs2_data,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        misalign_fault,
  output logic        bus_error,
  output logic        MEMWB_valid,
  output logic [6:0]  MEMWB_opcode_out,
  output logic [2:0]  MEMWB_funct3_out,
  output logic [4:0]  MEMWB_rd_out,
  output logic [31:0] MEMWB_data_addr_out,
  output logic [31:0] MEMWB_data_read,
  output logic [31:0] MEMWB_reg_write_data_out
);

  localparam int unsigned CNT_W = 32;

  mem_state_t     r_state, w_state_nxt;
  mem_op_t        w_in, r_op, w_op;
  logic [CNT_W-1:0] r_wait_cnt;
  logic           w_is_load, w_is_store, w_mem_op, w_bad, w_issue, w_we;
  logic           w_req, w_req_on, w_active, w_complete, w_timeout, w_stall, w_cnt_hit;
  logic [31:0]    w_wdata;
  logic [3:0]     w_be;

  assign w_in = '{opcode: EXMEM_opcode, funct3: EXMEM_funct3, rd: EXMEM_rd,
                  addr: EXMEM_alu_out, rs2: EXMEM_rs2_data};

  assign w_is_load  = EXMEM_valid && (EXMEM_opcode == OPC_LOAD);
  assign w_is_store = EXMEM_valid && (EXMEM_opcode == OPC_STORE);
  assign w_mem_op   = w_is_load || w_is_store;
  assign w_bad      = w_mem_op && (!is_legal_f3(w_is_store, EXMEM_funct3) ||
                                   is_misaligned(EXMEM_funct3, EXMEM_alu_out[1:0]));
  assign w_issue    = w_mem_op && !w_bad;

  // Once the request leaves IDLE the latched copy drives the bus so it stays stable.
  assign w_op      = (r_state == IDLE) ? w_in : r_op;
  assign w_we      = (w_op.opcode == OPC_STORE);
  assign w_cnt_hit = (RSP_TIMEOUT != 0) && (r_wait_cnt == CNT_W'(RSP_TIMEOUT - 1));

  store_align u_store_align (
    .i_funct3  (w_op.funct3),
    .i_offset  (w_op.addr[1:0]),
    .i_rs2     (w_op.rs2),
    .o_wdata_c (w_wdata),
    .o_be_c    (w_be)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_active    = 1'b0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          w_req    = 1'b1;
          w_active = 1'b1;
          if (!dmem_req_ready) w_state_nxt = REQ;
          else if (w_we)       w_complete  = 1'b1;
          else                 w_state_nxt = WAIT;
        end
      end
      REQ: begin
        w_req    = 1'b1;
        w_active = 1'b1;
        if (dmem_req_ready) begin
          if (w_we) begin
            w_complete  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        w_active = 1'b1;
        if (dmem_rsp_valid) begin
          w_complete  = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_cnt_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_stall  = w_active && !w_complete && !w_timeout;
  assign w_req_on = rst_n && w_req;

  assign dmem_req_valid = w_req_on;
  assign dmem_we        = w_req_on && w_we;
  assign dmem_addr      = w_req_on ? {w_op.addr[31:2], 2'b00} : 32'h0;
  assign dmem_wdata     = (w_req_on && w_we) ? w_wdata : 32'h0;
  assign dmem_be        = w_req_on ? (w_we ? w_be : 4'b1111) : 4'b0000;
  assign mem_stall      = rst_n && w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_wait_cnt <= '0;
    end else begin
      if (r_state == IDLE) r_op <= w_in;
      r_wait_cnt <= ((r_state == WAIT) && (w_state_nxt == WAIT)) ? r_wait_cnt + CNT_W'(1) : '0;
    end
  end

  // MEM/WB: bubble while stalled, finished op on completion/timeout, else pass-through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_fault           <= 1'b0;
      bus_error                <= 1'b0;
      MEMWB_valid              <= 1'b0;
      MEMWB_opcode_out         <= '0;
      MEMWB_funct3_out         <= '0;
      MEMWB_rd_out             <= '0;
      MEMWB_data_addr_out      <= '0;
      MEMWB_data_read          <= '0;
      MEMWB_reg_write_data_out <= '0;
    end else begin
      misalign_fault <= (r_state == IDLE) && w_bad;
      bus_error      <= w_timeout;
      if (w_stall) begin
        MEMWB_valid              <= 1'b0;
        MEMWB_opcode_out         <= '0;
        MEMWB_funct3_out         <= '0;
        MEMWB_rd_out             <= '0;
        MEMWB_data_addr_out      <= '0;
        MEMWB_data_read          <= '0;
        MEMWB_reg_write_data_out <= '0;
      end else if (w_complete || w_timeout) begin
        MEMWB_valid              <= w_complete;
        MEMWB_opcode_out         <= w_op.opcode;
        MEMWB_funct3_out         <= w_op.funct3;
        MEMWB_rd_out             <= w_op.rd;
        MEMWB_data_addr_out      <= w_op.addr;
        MEMWB_data_read          <= (w_complete && !w_we) ? dmem_rdata : 32'h0;
        MEMWB_reg_write_data_out <= w_op.addr;
      end else begin
        MEMWB_valid              <= EXMEM_valid && !w_bad;
        MEMWB_opcode_out         <= w_in.opcode;
        MEMWB_funct3_out         <= w_in.funct3;
        MEMWB_rd_out             <= w_in.rd;
        MEMWB_data_addr_out      <= w_in.addr;
        MEMWB_data_read          <= 32'h0;
        MEMWB_reg_write_data_out <= w_in.addr;
      end
    end
  end

endmodule
